// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder computing {c, s} = a + b + cin in STAGES equal chunks,
// one chunk per register stage, with the inter-chunk carry registered between stages.
// The last stage register is the output register, so latency is STAGES cycles and
// throughput is one result per cycle. Full valid/ready backpressure with bubble collapsing.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready is combinational from out_ready)
//   a, b, cin             operands and carry in
//   out_valid / out_ready result handshake
//   s, c, ovf             sum, carry out of MSB, signed overflow
module pipelined_adder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf
);

    localparam int unsigned CW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    if ((WIDTH < 1) || (STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("pipelined_adder: WIDTH must be >= 1 and a multiple of STAGES >= 1");
    end

    // Stage k holds: valid, carry out of chunk k, full operands (upper chunks still to be
    // added, MSBs needed for ovf) and the sum with chunks 0..k filled in.
    logic [STAGES-1:0] v_q, v_d, c_q, c_d, load;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];

    // What each stage would load: the input port for stage 0, the previous stage otherwise.
    logic [STAGES-1:0] src_v, src_c;
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];
    logic [CW:0]       chunk [STAGES];

    // A stage loads when it is empty or its downstream neighbour is loading from it;
    // this lets bubbles collapse and keeps full-pipe throughput at one per cycle.
    always_comb begin : p_load
        load       = '0;
        load[LAST] = !v_q[LAST] || out_ready;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            load[k] = !v_q[k] || load[k+1];
        end
    end

    always_comb begin : p_src
        src_v = '0;
        src_c = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            src_a[k] = '0;
            src_b[k] = '0;
            src_s[k] = '0;
        end
        src_v[0] = in_valid;
        src_c[0] = cin;
        src_a[0] = a;
        src_b[0] = b;
        for (int k = 1; k < int'(STAGES); k++) begin
            src_v[k] = v_q[k-1];
            src_c[k] = c_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
        end
    end

    always_comb begin : p_next
        v_d = '0;
        c_d = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            chunk[k] = {1'b0, src_a[k][k*CW +: CW]} + {1'b0, src_b[k][k*CW +: CW]}
                     + {{CW{1'b0}}, src_c[k]};
            v_d[k]   = src_v[k];
            c_d[k]   = chunk[k][CW];
            a_d[k]   = src_a[k];
            b_d[k]   = src_b[k];
            s_d[k]   = src_s[k];
            s_d[k][k*CW +: CW] = chunk[k][CW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (load[k]) begin
                    v_q[k] <= v_d[k];
                    // Data only moves with a valid item, so a bubble never disturbs it.
                    if (v_d[k]) begin
                        c_q[k] <= c_d[k];
                        a_q[k] <= a_d[k];
                        b_q[k] <= b_d[k];
                        s_q[k] <= s_d[k];
                    end
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = v_q[LAST];
    assign s         = s_q[LAST];
    assign c         = c_q[LAST];
    assign ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                    && (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule
